hist_lut_ctrl: RTL and testbench

Sequencer for the histogram-equalisation divider: on `start` it walks the CDF memory from address 0 to 2^ADDR_W-1. For each entry it reads the CDF value and issues it to the divider with a one-cycle `enable` pulse. It then waits for `ready_g_out` and writes the resulting `g_out` into the equalisation LUT at the same address. It sits between the CDF accumulation stage and the pixel-remap stage and owns the divider exclusively while `busy`.

---
 rtl/hist_lut_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hist_lut_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_lut_ctrl.sv
// hist_lut_ctrl: walks the CDF memory, feeds each entry to the divider
// and writes the divider result into the equalisation LUT.
// Optional feature macro: DIV_TIMEOUT_EN (abort a build when the divider stalls).
module hist_lut_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] cdf_addr,
  output logic              cdf_rd_en,
  input  logic [DATA_W-1:0] cdf_rdata,
  output logic              div_enable,
  output logic [DATA_W-1:0] div_cdf_in,
  input  logic [DATA_W-1:0] div_g_out,
  input  logic              div_ready,
  output logic [ADDR_W-1:0] lut_addr,
  output logic              lut_we,
  output logic [DATA_W-1:0] lut_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LATCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_last;
  logic              w_tmo;
  logic              w_go;

  logic              r_busy, r_done, r_rd_en, r_en, r_we;
  logic [ADDR_W-1:0] r_cdf_addr, r_lut_addr;
  logic [DATA_W-1:0] r_cdf_in, r_wdata;

  logic              w_busy_d, w_done_d, w_rd_d, w_en_d, w_we_d;
  logic [ADDR_W-1:0] w_addr_d;

  assign w_last = &r_idx;
  assign w_go   = (r_state == S_IDLE) && start;

`ifdef DIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_error;

  // Count cycles spent waiting on the divider
  always_ff @(posedge clk) begin
    if (reset || r_state != S_WAIT) r_tmo <= '0;
    else                            r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo = (r_state == S_WAIT) && !div_ready &&
                 (r_tmo == TW'(TIMEOUT - 1));

  // Sticky abort flag, cleared when a new build is accepted
  always_ff @(posedge clk) begin
    if (reset)      r_error <= 1'b0;
    else if (w_go)  r_error <= 1'b0;
    else if (w_tmo) r_error <= 1'b1;
  end

  assign error = r_error;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT != 0);
  assign w_tmo = 1'b0;
  assign error = 1'b0;
`endif

  // State and entry index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state decode; index wraps naturally after the last entry
  always_comb begin
    w_nxt     = r_state;
    w_idx_nxt = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt     = S_RD;
          w_idx_nxt = '0;
        end
      end
      S_RD:    w_nxt = S_LATCH;
      S_LATCH: w_nxt = S_ISSUE;
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT: begin
        if (div_ready)  w_nxt = S_WRITE;
        else if (w_tmo) w_nxt = S_DONE;
      end
      S_WRITE: begin
        w_nxt     = w_last ? S_DONE : S_RD;
        w_idx_nxt = r_idx + 1'b1;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    w_busy_d = (w_nxt != S_IDLE);
    w_done_d = (w_nxt == S_DONE);
    w_rd_d   = (w_nxt == S_RD);
    w_en_d   = (w_nxt == S_ISSUE);
    w_we_d   = (w_nxt == S_WRITE);
    w_addr_d = (w_nxt == S_IDLE) ? '0 : w_idx_nxt;
  end

  // Output registers; operand and result are zeroed whenever idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_cdf_addr <= '0;
      r_lut_addr <= '0;
      r_cdf_in   <= '0;
      r_wdata    <= '0;
    end else begin
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_rd_en    <= w_rd_d;
      r_en       <= w_en_d;
      r_we       <= w_we_d;
      r_cdf_addr <= w_addr_d;
      r_lut_addr <= w_addr_d;
      if (w_nxt == S_IDLE)        r_cdf_in <= '0;
      else if (r_state == S_LATCH) r_cdf_in <= cdf_rdata;
      if (w_nxt == S_IDLE)        r_wdata <= '0;
      else if (r_state == S_WAIT && div_ready)
        r_wdata <= div_g_out;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign cdf_rd_en  = r_rd_en;
  assign cdf_addr   = r_cdf_addr;
  assign div_enable = r_en;
  assign div_cdf_in = r_cdf_in;
  assign lut_addr   = r_lut_addr;
  assign lut_we     = r_we;
  assign lut_wdata  = r_wdata;

endmodule

// File: tb/tb_hist_lut_ctrl.sv
// tb_hist_lut_ctrl: random-stimulus bench with CDF RAM, divider and
// LUT reference models for hist_lut_ctrl.
module tb_hist_lut_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       busy, done, error;
  logic [7:0] cdf_addr, lut_addr;
  logic       cdf_rd_en, div_enable, div_ready, lut_we;
  logic [7:0] cdf_rdata, div_cdf_in, div_g_out, lut_wdata;

  hist_lut_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .cdf_addr(cdf_addr), .cdf_rd_en(cdf_rd_en), .cdf_rdata(cdf_rdata),
    .div_enable(div_enable), .div_cdf_in(div_cdf_in),
    .div_g_out(div_g_out), .div_ready(div_ready),
    .lut_addr(lut_addr), .lut_we(lut_we), .lut_wdata(lut_wdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_div(input logic [7:0] x);
    return 8'((int'(x) * 200) / 255);
  endfunction

  // CDF RAM: one-cycle read latency, junk when not read
  logic [7:0] mem [256];
  logic       ram_en;
  logic [7:0] ram_a;
  always @(posedge clk) begin
    ram_en = cdf_rd_en;
    ram_a  = cdf_addr;
    #1;
    cdf_rdata = ram_en ? mem[ram_a] : 8'($urandom);
  end

  // Divider: ready L cycles after the ISSUE cycle, junk otherwise
  bit   spur = 0, rand_l = 0;
  int   fix_l = 3, hang_idx = -1, hang_l = 0;
  int   en_cnt = 0, rem = 0, lat;
  bit   act = 0;
  logic [7:0] op;
  initial begin div_ready = 1'b0; div_g_out = '0; cdf_rdata = '0; end
  always @(posedge clk) begin
    if (reset) act = 0;
    else if (div_enable) begin
      act = 1;
      op  = div_cdf_in;
      lat = rand_l ? int'($urandom_range(1, 10)) : fix_l;
      if (en_cnt == hang_idx) lat = (hang_l == 0) ? 1 << 30 : hang_l;
      rem = lat - 1;
      en_cnt++;
    end else if (act) begin
      if (rem == 0) act = 0;
      else rem--;
    end
    #1;
    if (act && rem == 0) begin
      div_ready = 1'b1;
      div_g_out = ref_div(op);
    end else begin
      div_ready = (!act && spur) ? 1'($urandom) : 1'b0;
      div_g_out = 8'($urandom);
    end
  end

  // Monitor: capture LUT writes and protocol observations
  int lut [256];
  int nwr, n_en, ndone, ord_err, stab_err, last_addr;
  logic [7:0] exp_addr, op_at_en;
  always @(negedge clk) begin
    if (div_enable) begin
      n_en++;
      op_at_en = div_cdf_in;
    end
    if (lut_we) begin
      if (lut_addr != exp_addr) ord_err++;
      if (div_cdf_in != op_at_en) stab_err++;
      lut[lut_addr] = int'(lut_wdata);
      nwr++;
      last_addr = int'(lut_addr);
      exp_addr++;
    end
    if (done) ndone++;
  end

  task automatic clear_mon();
    #2;
    nwr = 0; n_en = 0; ndone = 0; ord_err = 0; stab_err = 0;
    last_addr = -1; exp_addr = '0; en_cnt = 0;
    for (int i = 0; i < 256; i++) lut[i] = -1;
  endtask

  function automatic int lut_bad();
    int b = 0;
    for (int i = 0; i < 256; i++)
      if (lut[i] != int'(ref_div(mem[i]))) b++;
    return b;
  endfunction

  task automatic wait_done(input int bound, output int n);
    n = 1;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic wait_en(input int target, input int bound);
    int k = 0;
    while (n_en < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("en_reached", n_en >= target, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_strb"}, {busy, done, error, cdf_rd_en, div_enable, lut_we}, 0);
    chk({tag, "_addr"}, {cdf_addr, lut_addr}, 0);
    chk({tag, "_data"}, {div_cdf_in, lut_wdata}, 0);
  endtask

  initial begin
    int n, k;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");

    // Build with identity CDF and constant latency 3
    reset = 1'b0;
    start = 1'b1;
    clear_mon();
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_rise", busy, 1);
    wait_done(4000, n);
    chk("build_cycles", n, 1793);
    chk("a_writes", nwr, 256);
    chk("a_enables", n_en, 256);
    chk("a_order", ord_err, 0);
    chk("a_lut", lut_bad(), 0);

    // Back-to-back restart, random data, random latency, spurious ready
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rand_l = 1;
    spur   = 1;
    start  = 1'b1;
    clear_mon();
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("done_pulse", done, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1);
    wait_done(8000, n);
    chk("b_writes", nwr, 256);
    chk("b_enables", n_en, 256);
    chk("b_order", ord_err, 0);
    chk("b_stable", stab_err, 0);
    chk("b_lut", lut_bad(), 0);

    // Ignored mid-build start, then reset while on entry 100
    rand_l = 0;
    spur   = 0;
    fix_l  = 2;
    @(negedge clk);
    start = 1'b1;
    clear_mon();
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (nwr < 50 && k < 2000) begin @(negedge clk); k++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en(101, 2000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("midrst");
    repeat (40) @(negedge clk);
    chk("c_no_done", ndone, 0);
    chk("c_writes", nwr, 100);
    chk("c_last_le100", last_addr <= 100, 1);
    chk("c_order", ord_err, 0);
    chk("c_stable", stab_err, 0);

`ifdef DIV_TIMEOUT_EN
    // Divider never answers entry 5
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    hang_idx = 5;
    hang_l   = 0;
    start    = 1'b1;
    clear_mon();
    @(posedge clk);
    #1 start = 1'b0;
    wait_en(6, 500);
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    chk("tmo_cycles", n, 65);
    chk("tmo_error", error, 1);
    chk("tmo_writes", nwr, 5);
    chk("tmo_last", last_addr, 4);
    @(negedge clk);
    chk("tmo_sticky", error, 1);
    chk("tmo_idle", busy, 0);
    hang_idx = -1;
    start    = 1'b1;
    clear_mon();
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("tmo_clear", error, 0);
    wait_done(4000, n);
    chk("tmo_rebuild", nwr, 256);
    chk("tmo_lut", lut_bad(), 0);
`else
    // Divider withholds ready for 500 cycles on entry 5
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    hang_idx = 5;
    hang_l   = 500;
    start    = 1'b1;
    clear_mon();
    @(posedge clk);
    #1 start = 1'b0;
    wait_en(6, 500);
    repeat (490) @(negedge clk);
    chk("hold_busy", busy, 1);
    chk("hold_writes", nwr, 5);
    chk("hold_err", error, 0);
    wait_done(4000, n);
    chk("hold_total", nwr, 256);
    chk("hold_lut", lut_bad(), 0);
    chk("hold_err_end", error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
